bridge_tx: RTL and testbench

// - Response side of the host bridge. Takes one read result from the internal bus and

---
 rtl/bridge_pkg.sv | 17 +
 rtl/bridge_tx.sv | 84 ++++++++
 tb/tb_bridge_tx.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bridge_pkg.sv
// Shared framing definitions for the host bridge: ASCII markers, hex encoding
// and the transmit state type. bridge_rx decodes with the same constants.
package bridge_pkg;

    localparam logic [7:0] PREAMBLE_CHAR = 8'h4D;
    localparam logic [7:0] CR            = 8'h0D;
    localparam logic [7:0] LF            = 8'h0A;

    typedef enum logic {IDLE, SEND} bridge_tx_state_t;

    // Uppercase only, so the host parser never has to fold case.
    function automatic logic [7:0] to_ascii_hex(input logic [3:0] nib);
        if (nib < 4'd10) return 8'h30 + {4'h0, nib};
        return 8'h41 + ({4'h0, nib} - 8'd10);
    endfunction

endpackage

// File: rtl/bridge_tx.sv
// Response side of the host bridge: serialises one read result as
// "M" + hex digits (MS nibble first) + CR + LF over a byte valid/ready handshake.
module bridge_tx
    import bridge_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic                  rw_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [7:0]            data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  busy_o
);

    localparam int N     = DATA_WIDTH / 4;
    localparam int CNT_W = $clog2(N + 3);
    localparam int SEL_W = $clog2(DATA_WIDTH);

    localparam logic [CNT_W-1:0] IDX_CR = CNT_W'(N + 1);
    localparam logic [CNT_W-1:0] IDX_LF = CNT_W'(N + 2);

    bridge_tx_state_t      state;
    logic [DATA_WIDTH-1:0] hold;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      next_idx;
    logic [SEL_W-3:0]      nib_sel;
    logic [7:0]            next_byte;

    // Byte index k (1..N) carries nibble N-k, so the MS nibble goes out first.
    always_comb begin
        next_idx  = cnt + 1'b1;
        nib_sel   = (SEL_W-2)'(CNT_W'(N) - next_idx);
        next_byte = to_ascii_hex(hold[{nib_sel, 2'b00} +: 4]);
        if (next_idx == IDX_CR)
            next_byte = CR;
        else if (next_idx == IDX_LF)
            next_byte = LF;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            hold    <= '0;
            cnt     <= '0;
            data_o  <= 8'h00;
            valid_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i && !rw_i) begin
                        hold    <= rdata_i;
                        cnt     <= '0;
                        data_o  <= PREAMBLE_CHAR;
                        valid_o <= 1'b1;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (ready_i) begin
                        if (cnt == IDX_LF) begin
                            state   <= IDLE;
                            cnt     <= '0;
                            data_o  <= 8'h00;
                            valid_o <= 1'b0;
                        end else begin
                            cnt    <= next_idx;
                            data_o <= next_byte;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ready_o = (state == IDLE);
    assign busy_o  = !ready_o;

endmodule

// File: tb/tb_bridge_tx.sv
// Self-checking bench for bridge_tx: table vectors, handshake corner cases,
// randomized reads against a string-based reference model, and a 32-bit instance.
module tb_bridge_tx;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        logic [15:0] data;
        logic        rw;
        int          mode;
        string       hex;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] rdata_i = '0;
    logic        rw_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic        busy_o;

    logic [31:0] rdata32 = '0;
    logic        rw32 = 1'b0;
    logic        valid32 = 1'b0;
    logic        ready32_o;
    logic [7:0]  data32;
    logic        valid32_o;
    logic        busy32;

    int  n_checks = 0;
    int  n_fail   = 0;
    int  rmode    = 0;
    bq_t got_q;
    bq_t got32_q;

    always #5 clk = ~clk;

    bridge_tx #(.DATA_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .rdata_i(rdata_i), .rw_i(rw_i), .valid_i(valid_i),
        .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
        .busy_o(busy_o)
    );

    bridge_tx #(.DATA_WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .rdata_i(rdata32), .rw_i(rw32), .valid_i(valid32),
        .ready_o(ready32_o), .data_o(data32), .valid_o(valid32_o), .ready_i(1'b1),
        .busy_o(busy32)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: format the value with $sformatf, fold to uppercase, frame it.
    function automatic string model_msg(input logic [31:0] v, input int nd);
        string h;
        string r;
        byte   c;
        h = $sformatf("%08h", v);
        r = "M";
        for (int i = 8 - nd; i < 8; i++) begin
            c = h[i];
            if (c >= 8'h61 && c <= 8'h66) c = c - 8'd32;
            r = $sformatf("%s%c", r, c);
        end
        return $sformatf("%s%c%c", r, 8'h0D, 8'h0A);
    endfunction

    function automatic string crlf(input string s);
        return $sformatf("%s%c%c", s, 8'h0D, 8'h0A);
    endfunction

    task automatic cmp_msg(input string name, input bq_t got, input string exp);
        chk({name, " length"}, 64'(got.size()), 64'(exp.len()));
        for (int i = 0; i < exp.len() && i < got.size(); i++)
            chk($sformatf("%s byte%0d", name, i), 64'(got[i]), 64'(exp[i]));
    endtask

    // Transfers are observed on the negedge preceding the edge that completes them.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall valid_o held", 64'(valid_o), 64'(1));
                chk("stall data_o held", 64'(data_o), 64'(prev_data));
            end
            if (valid_o && ready_i) got_q.push_back(data_o);
            prev_stall = valid_o && !ready_i;
            prev_data  = data_o;
            if (valid32_o) got32_q.push_back(data32);
        end
    end

    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       ready_i = 1'b1;
            1:       ready_i = ~ready_i;
            default: ready_i = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (!ready_o && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ready_o) chk("idle wait timeout", 64'(ready_o), 64'(1));
    endtask

    task automatic start_msg(input logic [15:0] d, input logic rw);
        wait_idle();
        @(posedge clk); #1;
        got_q.delete();
        rdata_i = d;
        rw_i    = rw;
        valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        rw_i    = 1'b0;
        if (!rw) begin
            chk("first byte valid_o", 64'(valid_o), 64'(1));
            chk("first byte M", 64'(data_o), 64'h4D);
            chk("busy ready_o", 64'(ready_o), 64'(0));
            chk("busy busy_o", 64'(busy_o), 64'(1));
        end else begin
            chk("write ack valid_o", 64'(valid_o), 64'(0));
            chk("write ack ready_o", 64'(ready_o), 64'(1));
        end
    endtask

    task automatic finish_msg(input string name, input string exp, output int cycles);
        cycles = 0;
        while (!ready_o && cycles < 300) begin
            @(posedge clk); #1;
            cycles++;
        end
        chk({name, " completes"}, 64'(ready_o), 64'(1));
        chk({name, " gap valid_o"}, 64'(valid_o), 64'(0));
        cmp_msg(name, got_q, exp);
    endtask

    task automatic check_write_ack();
        int bad;
        bad = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (valid_o || !ready_o) bad++;
        end
        chk("write ack quiet cycles", 64'(bad), 64'(0));
        chk("write ack no bytes", 64'(got_q.size()), 64'(0));
    endtask

    vec_t tbl[5];

    initial begin
        int cyc;
        logic [15:0] v;
        logic        rw;

        tbl[0] = '{16'h1234, 1'b0, 0, "1234"};
        tbl[1] = '{16'hBEEF, 1'b0, 1, "BEEF"};
        tbl[2] = '{16'hDEAD, 1'b1, 0, ""};
        tbl[3] = '{16'h0A5F, 1'b0, 2, "0A5F"};
        tbl[4] = '{16'h9C07, 1'b0, 1, "9C07"};

        repeat (3) @(posedge clk);
        #1;
        chk("reset data_o", 64'(data_o), 64'h00);
        chk("reset valid_o", 64'(valid_o), 64'(0));
        chk("reset ready_o", 64'(ready_o), 64'(1));
        chk("reset busy_o", 64'(busy_o), 64'(0));
        rst = 1'b0;

        foreach (tbl[i]) begin
            rmode = tbl[i].mode;
            start_msg(tbl[i].data, tbl[i].rw);
            if (tbl[i].rw) begin
                check_write_ack();
            end else begin
                finish_msg($sformatf("vec%0d", i), crlf({"M", tbl[i].hex}), cyc);
                if (tbl[i].mode == 0) chk($sformatf("vec%0d cycles", i), 64'(cyc), 64'(7));
            end
        end

        // Read issued while busy is dropped; the active message is unaffected.
        rmode = 1;
        start_msg(16'hBEEF, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        rdata_i = 16'h0000;
        valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        chk("drop still busy", 64'(ready_o), 64'(0));
        finish_msg("drop", crlf("MBEEF"), cyc);
        rmode = 0;
        start_msg(16'hF00D, 1'b0);
        finish_msg("after drop", crlf("MF00D"), cyc);

        // Reset mid-message abandons it; the next read starts from "M".
        start_msg(16'hCAFE, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        chk("pre-reset byte count", 64'(got_q.size()), 64'(3));
        rst = 1'b1;
        #1;
        chk("mid reset valid_o", 64'(valid_o), 64'(0));
        chk("mid reset ready_o", 64'(ready_o), 64'(1));
        chk("mid reset busy_o", 64'(busy_o), 64'(0));
        chk("mid reset data_o", 64'(data_o), 64'h00);
        @(posedge clk); #1;
        rst = 1'b0;
        start_msg(16'hB0BA, 1'b0);
        finish_msg("after reset", crlf("MB0BA"), cyc);

        // Randomized reads and write acks against the string model.
        for (int k = 0; k < 25; k++) begin
            v     = 16'($urandom);
            rw    = ($urandom_range(0, 3) == 0);
            rmode = $urandom_range(0, 2);
            start_msg(v, rw);
            if (rw) check_write_ack();
            else    finish_msg($sformatf("rand%0d", k), model_msg({16'h0, v}, 4), cyc);
        end
        rmode = 0;

        // Wide instance.
        @(posedge clk); #1;
        got32_q.delete();
        rdata32 = 32'hDEADBEEF;
        valid32 = 1'b1;
        @(posedge clk); #1;
        valid32 = 1'b0;
        chk("w32 first byte", 64'(data32), 64'h4D);
        cyc = 0;
        while (!ready32_o && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("w32 completes", 64'(ready32_o), 64'(1));
        chk("w32 cycles", 64'(cyc), 64'(11));
        cmp_msg("w32", got32_q, crlf("MDEADBEEF"));

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
